// File: rtl/p251_rej_sampler.sv
// Rejection sampler: splits XOF words into bytes (LSB first) and emits the
// bytes below 251 as mod-251 field elements until N_ELEM have been produced.
module p251_rej_sampler #(
    parameter int WORD_BYTES = 4,
    parameter int N_ELEM     = 16,
    parameter int IDX_W      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [8*WORD_BYTES-1:0] i_word,
    input  logic                    i_word_valid,
    output logic                    o_word_ready,
    output logic [7:0]              o_elem,
    output logic [IDX_W-1:0]        o_elem_idx,
    output logic                    o_elem_valid,
    output logic [15:0]             o_rej_cnt,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BI_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CNT_W = $clog2(N_ELEM + 1);
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_ELEM - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_FIN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [BI_W-1:0]         bidx_q, bidx_d;
    logic [8*WORD_BYTES-1:0] shift_q, shift_d;
    logic [7:0]              elem_q, elem_d;
    logic [IDX_W-1:0]        eidx_q, eidx_d;
    logic                    valid_q, valid_d;
    logic [15:0]             rej_q, rej_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [7:0] cur_byte;
    logic       cur_ok;

    assign cur_byte = shift_q[7:0];
    assign cur_ok   = (cur_byte <= 8'd250);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        elem_d  = elem_q;
        eidx_d  = eidx_q;
        valid_d = 1'b0;
        rej_d   = rej_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    count_d = '0;
                    rej_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_word_valid) begin
                    shift_d = i_word;
                    bidx_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                shift_d = shift_q >> 8;
                if (cur_ok) begin
                    elem_d  = cur_byte;
                    eidx_d  = IDX_W'(count_q);
                    valid_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else if (rej_q != 16'hFFFF) begin
                    rej_d = rej_q + 16'd1;
                end
                // Finishing drops the rest of the word without counting it as rejected.
                if (cur_ok && (count_q == LAST_CNT)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else if (bidx_q == LAST_BYTE) begin
                    state_d = S_LOAD;
                end else begin
                    bidx_d = bidx_q + BI_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            elem_q  <= '0;
            eidx_q  <= '0;
            valid_q <= 1'b0;
            rej_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            elem_q  <= elem_d;
            eidx_q  <= eidx_d;
            valid_q <= valid_d;
            rej_q   <= rej_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_word_ready = (state_q == S_LOAD);
    assign o_elem       = elem_q;
    assign o_elem_idx   = eidx_q;
    assign o_elem_valid = valid_q;
    assign o_rej_cnt    = rej_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_p251_rej_sampler.sv
// Self-checking bench for p251_rej_sampler: directed scenarios plus random
// word streams compared against a byte-stream rejection model.
module tb_p251_rej_sampler;

    localparam int WB = 4;
    localparam int N  = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [8*WB-1:0] i_word = '0;
    logic          i_word_valid = 1'b0;
    logic          o_word_ready;
    logic [7:0]    o_elem;
    logic [IW-1:0] o_elem_idx;
    logic          o_elem_valid;
    logic [15:0]   o_rej_cnt;
    logic          o_busy;
    logic          o_done;

    always #5 clk = ~clk;

    p251_rej_sampler #(.WORD_BYTES(WB), .N_ELEM(N), .IDX_W(IW)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_word(i_word), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready),
        .o_elem(o_elem), .o_elem_idx(o_elem_idx), .o_elem_valid(o_elem_valid),
        .o_rej_cnt(o_rej_cnt), .o_busy(o_busy), .o_done(o_done)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus words and model expectations
    logic [31:0] word_q[$];
    int exp_elem[$];
    int exp_rej;
    int exp_words;

    // Observations from the last run
    int got_elem[$];
    int got_idx[$];
    int got_cyc[$];
    int acc_cyc[$];
    int done_cnt, done_last, busy_low, ready_cnt, post_bad, rej_at_done, rej_post;
    bit timed_out;

    // Flat byte stream, LSB first; keep bytes < 251 until N elements exist.
    task automatic model();
        exp_elem.delete();
        exp_rej   = 0;
        exp_words = 0;
        for (int w = 0; w < word_q.size() && exp_elem.size() < N; w++) begin
            exp_words++;
            for (int b = 0; b < WB && exp_elem.size() < N; b++) begin
                int v;
                v = int'((word_q[w] >> (8 * b)) & 32'hFF);
                if (v < 251) exp_elem.push_back(v);
                else exp_rej++;
            end
        end
    endtask

    // Drives one run; stall_len refusals of the word at index stall_at,
    // optional extra i_start at cycle extra_start and in the o_done cycle,
    // and abort (return early) once abort_after elements have been seen.
    task automatic drive_run(input int stall_at, input int stall_len,
                             input int extra_start, input int abort_after);
        int wp;
        int stall;
        int cyc;
        wp = 0; stall = stall_len; cyc = 0;
        got_elem.delete(); got_idx.delete(); got_cyc.delete(); acc_cyc.delete();
        done_cnt = 0; done_last = 0; busy_low = 0; ready_cnt = 0; post_bad = 0;
        rej_at_done = -1; rej_post = -1; timed_out = 0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        while (1) begin
            if (o_elem_valid) begin
                got_elem.push_back(int'(o_elem));
                got_idx.push_back(int'(o_elem_idx));
                got_cyc.push_back(cyc);
            end
            if (o_done) begin
                done_cnt++;
                done_last = (o_elem_valid && int'(o_elem_idx) == N - 1) ? 1 : 0;
                rej_at_done = int'(o_rej_cnt);
            end
            if (!o_busy) busy_low++;
            if (o_word_ready) ready_cnt++;
            i_start = (extra_start >= 0) && (cyc == extra_start || o_done);
            if (abort_after > 0 && got_elem.size() >= abort_after) begin
                i_word_valid = 1'b0; i_start = 1'b0;
                return;
            end
            if (o_done) break;
            if (cyc >= 400) begin
                timed_out = 1;
                break;
            end
            if (o_word_ready && !(wp == stall_at && stall > 0)) begin
                i_word_valid = 1'b1;
                i_word = (wp < word_q.size()) ? word_q[wp] : $urandom;
                acc_cyc.push_back(cyc);
                wp++;
            end else begin
                if (o_word_ready) begin
                    stall--;
                    i_word_valid = 1'b0;
                end else begin
                    i_word_valid = 1'($urandom_range(0, 1));
                end
                i_word = $urandom;
            end
            @(negedge clk); cyc++;
        end
        i_word_valid = 1'b0;
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_elem_valid || o_done || o_busy || o_word_ready) post_bad++;
            if (got_elem.size() > 0 &&
                (int'(o_elem) != got_elem[$] || int'(o_elem_idx) != got_idx[$])) post_bad++;
        end
        rej_post = int'(o_rej_cnt);
        $display("run: words=%0d elems=%0d rej=%0d done=%0d", acc_cyc.size(),
                 got_elem.size(), rej_post, done_cnt);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (o_elem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_elem_valid); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
        checks++; if (o_word_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", o_word_ready); end
        checks++; if (o_rej_cnt !== 16'd0 || o_elem !== 8'd0 || o_elem_idx !== '0) begin
            errors++; $display("FAIL reset_data got rej=%0d elem=%0d idx=%0d want 0/0/0", o_rej_cnt, o_elem, o_elem_idx);
        end
        i_rst_n = 1'b1;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0 || o_word_ready !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy=%0b ready=%0b want 0/0", o_busy, o_word_ready);
        end
    endtask

    task automatic test_basic();
        word_q = '{32'h04030201};
        model();
        drive_run(-1, 0, -1, 0);
        checks++; if (timed_out || got_elem.size() != N) begin errors++; $display("FAIL basic_count got %0d want %0d", got_elem.size(), N); end
        for (int k = 0; k < got_elem.size() && k < N; k++) begin
            checks++; if (got_elem[k] != exp_elem[k] || got_idx[k] != k) begin
                errors++; $display("FAIL basic_elem%0d got (%0d,%0d) want (%0d,%0d)", k, got_elem[k], got_idx[k], exp_elem[k], k);
            end
            checks++; if (got_cyc[k] != acc_cyc[0] + 2 + k) begin
                errors++; $display("FAIL basic_lat%0d got cycle %0d want %0d", k, got_cyc[k], acc_cyc[0] + 2 + k);
            end
        end
        checks++; if (ready_cnt != 1) begin errors++; $display("FAIL basic_ready got %0d cycles want 1", ready_cnt); end
        checks++; if (done_cnt != 1 || done_last != 1) begin errors++; $display("FAIL basic_done got cnt=%0d withlast=%0d want 1/1", done_cnt, done_last); end
        checks++; if (rej_post != exp_rej || rej_at_done != exp_rej) begin errors++; $display("FAIL basic_rej got %0d/%0d want %0d", rej_at_done, rej_post, exp_rej); end
        checks++; if (post_bad != 0 || busy_low != 0) begin errors++; $display("FAIL basic_post got post=%0d busylow=%0d want 0/0", post_bad, busy_low); end
    endtask

    task automatic test_boundary();
        word_q = '{32'hFBFC01FA, 32'h00000000};
        model();
        drive_run(-1, 0, -1, 0);
        checks++; if (timed_out || got_elem.size() != N) begin errors++; $display("FAIL bound_count got %0d want %0d", got_elem.size(), N); end
        for (int k = 0; k < got_elem.size() && k < N; k++) begin
            checks++; if (got_elem[k] != exp_elem[k] || got_idx[k] != k) begin
                errors++; $display("FAIL bound_elem%0d got (%0d,%0d) want (%0d,%0d)", k, got_elem[k], got_idx[k], exp_elem[k], k);
            end
        end
        checks++; if (rej_post != 2 || exp_rej != 2) begin errors++; $display("FAIL bound_rej got %0d want 2", rej_post); end
        checks++; if (ready_cnt != 2 || done_cnt != 1) begin errors++; $display("FAIL bound_flow got ready=%0d done=%0d want 2/1", ready_cnt, done_cnt); end
    endtask

    task automatic test_early_term();
        word_q = '{32'hFFFFFF05, 32'h0A090807};
        model();
        drive_run(-1, 0, -1, 0);
        checks++; if (timed_out || got_elem.size() != N) begin errors++; $display("FAIL early_count got %0d want %0d", got_elem.size(), N); end
        for (int k = 0; k < got_elem.size() && k < N; k++) begin
            checks++; if (got_elem[k] != exp_elem[k] || got_idx[k] != k) begin
                errors++; $display("FAIL early_elem%0d got (%0d,%0d) want (%0d,%0d)", k, got_elem[k], got_idx[k], exp_elem[k], k);
            end
        end
        checks++; if (rej_post != exp_rej) begin errors++; $display("FAIL early_rej got %0d want %0d", rej_post, exp_rej); end
        checks++; if (done_last != 1 || post_bad != 0) begin errors++; $display("FAIL early_done got withlast=%0d post=%0d want 1/0", done_last, post_bad); end
    endtask

    task automatic test_stall();
        word_q = '{32'hFFFF0201, 32'h00FB0403};
        model();
        drive_run(1, 5, -1, 0);
        checks++; if (timed_out || got_elem.size() != N) begin errors++; $display("FAIL stall_count got %0d want %0d", got_elem.size(), N); end
        for (int k = 0; k < got_elem.size() && k < N; k++) begin
            checks++; if (got_elem[k] != exp_elem[k] || got_idx[k] != k) begin
                errors++; $display("FAIL stall_elem%0d got (%0d,%0d) want (%0d,%0d)", k, got_elem[k], got_idx[k], exp_elem[k], k);
            end
        end
        checks++; if (busy_low != 0 || ready_cnt != 7) begin errors++; $display("FAIL stall_hold got busylow=%0d ready=%0d want 0/7", busy_low, ready_cnt); end
        checks++; if (acc_cyc.size() != 2 || got_elem.size() != N || acc_cyc[1] != acc_cyc[0] + WB + 1 + 5 || got_cyc[2] != acc_cyc[1] + 2) begin
            errors++; $display("FAIL stall_timing got words=%0d strobes=%0d want 2/%0d with resume 2 cycles after accept", acc_cyc.size(), got_elem.size(), N);
        end
        checks++; if (rej_post != exp_rej) begin errors++; $display("FAIL stall_rej got %0d want %0d", rej_post, exp_rej); end
    endtask

    task automatic test_reset_mid();
        word_q = '{32'h04030201};
        drive_run(-1, 0, -1, 2);
        i_rst_n = 1'b0;
        @(negedge clk);
        checks++; if (o_elem_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_word_ready !== 1'b0 ||
                      o_elem !== 8'd0 || o_elem_idx !== '0 || o_rej_cnt !== 16'd0) begin
            errors++; $display("FAIL midreset_outs got v=%0b b=%0b d=%0b r=%0b e=%0d i=%0d rej=%0d want all 0",
                               o_elem_valid, o_busy, o_done, o_word_ready, o_elem, o_elem_idx, o_rej_cnt);
        end
        i_rst_n = 1'b1;
        word_q = '{32'h08070605};
        model();
        drive_run(-1, 0, -1, 0);
        checks++; if (timed_out || got_elem.size() != N) begin errors++; $display("FAIL midreset_count got %0d want %0d", got_elem.size(), N); end
        for (int k = 0; k < got_elem.size() && k < N; k++) begin
            checks++; if (got_elem[k] != exp_elem[k] || got_idx[k] != k) begin
                errors++; $display("FAIL midreset_elem%0d got (%0d,%0d) want (%0d,%0d)", k, got_elem[k], got_idx[k], exp_elem[k], k);
            end
        end
    endtask

    task automatic test_start_ignored();
        word_q = '{32'hFE03FD01, 32'hFF0605FF};
        model();
        drive_run(-1, 0, 3, 0);
        checks++; if (timed_out || got_elem.size() != N) begin errors++; $display("FAIL ignstart_count got %0d want %0d", got_elem.size(), N); end
        for (int k = 0; k < got_elem.size() && k < N; k++) begin
            checks++; if (got_elem[k] != exp_elem[k] || got_idx[k] != k) begin
                errors++; $display("FAIL ignstart_elem%0d got (%0d,%0d) want (%0d,%0d)", k, got_elem[k], got_idx[k], exp_elem[k], k);
            end
        end
        checks++; if (done_cnt != 1 || post_bad != 0) begin errors++; $display("FAIL ignstart_done got done=%0d post=%0d want 1/0", done_cnt, post_bad); end
        checks++; if (rej_post != exp_rej) begin errors++; $display("FAIL ignstart_rej got %0d want %0d", rej_post, exp_rej); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            word_q.delete();
            do begin
                logic [31:0] w;
                for (int b = 0; b < WB; b++)
                    w[8*b +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(245, 255)) : 8'($urandom_range(0, 255));
                word_q.push_back(w);
                model();
            end while (exp_elem.size() < N);
            drive_run(-1, 0, -1, 0);
            checks++; if (timed_out || got_elem.size() != N) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, got_elem.size(), N); end
            for (int k = 0; k < got_elem.size() && k < N; k++) begin
                checks++; if (got_elem[k] != exp_elem[k] || got_idx[k] != k) begin
                    errors++; $display("FAIL rand%0d_elem%0d got (%0d,%0d) want (%0d,%0d)", r, k, got_elem[k], got_idx[k], exp_elem[k], k);
                end
            end
            checks++; if (rej_post != exp_rej || ready_cnt != exp_words || done_last != 1 || post_bad != 0) begin
                errors++; $display("FAIL rand%0d_run got rej=%0d words=%0d withlast=%0d post=%0d want %0d/%0d/1/0",
                                   r, rej_post, ready_cnt, done_last, post_bad, exp_rej, exp_words);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_early_term();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
